mul64_seq: RTL and testbench

Multi-cycle unsigned 64×64→128-bit shift-and-add multiplier for the execute stage. It is the direct consumer of `Adder64`: one `Adder64` instance performs the single add of each iteration, and its 65-bit result (carry + sum) is shifted into the accumulator. It uses a valid/ready handshake on both sides. It accepts one operation at a time and returns the full 128-bit product after a fixed latency.

---
 rtl/mul64_seq_pkg.sv | 21 ++
 rtl/mul64_seq_adder.sv | 18 +
 rtl/mul64_seq.sv | 111 +++++++++++
 tb/tb_mul64_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mul64_seq_pkg.sv
// mul64_seq_pkg: shared definitions for the sequential 64x64 multiplier.
//   mul_state_e  - control FSM states (IDLE / BUSY / DONE)
//   MUL_ITERS    - add-and-shift iterations per product
//   MUL_CNT_W    - iteration counter width
//   MUL_PROD_W   - full product width
package mul64_seq_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int unsigned MUL_ITERS  = 64;
  localparam int unsigned MUL_CNT_W  = 6;
  localparam int unsigned MUL_PROD_W = 128;

  // Counter value seen on the edge that performs the final iteration.
  localparam logic [MUL_CNT_W-1:0] MUL_LAST_CNT = MUL_CNT_W'(MUL_ITERS - 1);

endpackage

// File: rtl/mul64_seq_adder.sv
// Adder64: 64-bit unsigned adder with carry in and carry out.
//   a, b  in  64  addends
//   cin   in  1   carry in
//   sum   out 64  low 64 bits of a + b + cin
//   cout  out 1   carry out (bit 64 of the result)
module Adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};
  end

endmodule

// File: rtl/mul64_seq.sv
// mul64_seq: multi-cycle unsigned 64x64 -> 128-bit shift-and-add multiplier.
//   clk        in  1    clock, rising edge
//   rst_n      in  1    asynchronous active-low reset
//   in_valid   in  1    operands present
//   in_ready   out 1    block can accept (IDLE only)
//   in_a       in  64   multiplicand
//   in_b       in  64   multiplier
//   out_valid  out 1    product available (DONE only)
//   out_ready  in  1    consumer takes product
//   out_prod   out 128  unsigned product {hi, lo}
//   busy       out 1    iterating (BUSY)
module mul64_seq
  import mul64_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_a,
  input  logic [63:0]           in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MUL_PROD_W-1:0] out_prod,
  output logic                  busy
);

  mul_state_e           state_q, state_d;
  logic [63:0]          mcand_q, mcand_d;
  logic [63:0]          acc_hi_q, acc_hi_d;
  logic [63:0]          acc_lo_q, acc_lo_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0] addend;
  logic [63:0] add_sum;
  logic        add_cout;

  // Only partial-product selection sits in front of the adder.
  always_comb begin
    addend = acc_lo_q[0] ? mcand_q : '0;
  end

  Adder64 u_adder (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      MUL_IDLE: begin
        if (in_valid) begin
          mcand_d  = in_a;
          acc_lo_d = in_b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        // {carry, sum, acc_lo} shifted right by one: the carry becomes the
        // top accumulator bit so no product bit is ever lost.
        {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[63:1]};
        cnt_d = cnt_q + MUL_CNT_W'(1);
        if (cnt_q == MUL_LAST_CNT) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (out_ready) begin
          state_d = MUL_IDLE;
        end
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  // Handshake outputs decode registered state only.
  always_comb begin
    in_ready  = (state_q == MUL_IDLE);
    out_valid = (state_q == MUL_DONE);
    busy      = (state_q == MUL_BUSY);
    out_prod  = {acc_hi_q, acc_lo_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul64_seq.sv
module tb_mul64_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_a;
  logic [63:0]  in_b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_prod;
  logic         busy;

  int unsigned checks;
  int unsigned errors;

  mul64_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, check latency/product, stall for
  // 'stall' cycles in DONE, then complete the handshake.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp, input int unsigned stall);
    int unsigned cyc;
    logic [127:0] held;
    check({tag, "_in_ready_idle"}, {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    in_a = $urandom();
    in_b = $urandom();
    check({tag, "_busy"}, {126'd0, busy, in_ready}, 128'd2);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 128'(cyc), 128'd64);
    check({tag, "_prod"}, out_prod, exp);
    held = out_prod;
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_hold"}, {out_valid, in_ready, busy, held[124:0]},
            {3'b100, out_prod[124:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {125'd0, out_valid, in_ready, busy}, 128'd2);
  endtask

  initial begin
    logic [63:0]  ra;
    logic [63:0]  rb;
    logic [127:0] held;
    int unsigned  cyc;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
    check("reset_prod", out_prod, 128'd0);

    // Directed vectors
    run_op("3x5", 64'd3, 64'd5, 128'h0F, 0);
    run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0);
    run_op("pow32", 64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000, 2);
    run_op("msb_x2", 64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000, 0);
    run_op("max_x1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("a_x_zero", 64'h1234_5678_9ABC_DEF0, 64'd0, 128'd0, 0);

    // Zero with back-pressure and an ignored second request
    check("zero_in_ready_idle", {127'd0, in_ready}, 128'd1);
    in_valid  = 1'b1;
    in_a      = 64'd0;
    in_b      = 64'hDEAD_BEEF;
    out_ready = 1'b0;
    tick();
    in_a = 64'd9;
    in_b = 64'd9;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      check("zero_in_ready_busy", {127'd0, in_ready}, 128'd0);
      tick();
      cyc++;
    end
    check("zero_latency", 128'(cyc), 128'd64);
    check("zero_prod", out_prod, 128'd0);
    held = out_prod;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("zero_stall", {out_valid, in_ready, held[125:0]}, {2'b10, out_prod[125:0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("zero_release", {126'd0, out_valid, in_ready}, 128'd1);
    tick();
    check("zero_no_extra_accept", {126'd0, busy, in_ready}, 128'd1);

    // Abort mid-BUSY
    in_valid = 1'b1;
    in_a     = 64'h1234;
    in_b     = 64'h5678;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    check("abort_busy_before", {127'd0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("abort_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
    check("abort_prod", out_prod, 128'd0);
    repeat (2) tick();
    check("abort_held", {125'd0, in_ready, out_valid, busy}, 128'd4);
    rst_n = 1'b1;
    tick();
    run_op("7x6", 64'd7, 64'd6, 128'h2A, 0);

    // Random operands against a 128-bit reference product
    for (int unsigned n = 0; n < 20; n++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      run_op("rand", ra, rb, {64'd0, ra} * {64'd0, rb}, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
